// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution window address generator.
package cnn_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } cnn_agen_state_e;

   // Number of window positions along one axis for a valid (unpadded) convolution.
   function automatic int cnn_out_dim(input int size, input int kernel, input int stride);
      return (size - kernel) / stride + 1;
   endfunction

endpackage

// File: rtl/cnn_counter.sv
// Enabled wrap-around counter; pulse_o marks the enabled step that wraps back to zero.
module cnn_counter #(
   parameter int max_p = 4,
   parameter int stride_p = 1,
   localparam int count_width_lp = (max_p > 1) ? $clog2(max_p) : 1
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      en_i,
   output logic [count_width_lp-1:0] count_o,
   output logic                      pulse_o
);

   logic [count_width_lp-1:0] count_q;
   logic                      wrap;

   assign wrap    = (int'(count_q) + stride_p) >= max_p;
   assign pulse_o = en_i & wrap;
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else if (en_i) begin
         count_q <= wrap ? '0 : count_q + count_width_lp'(stride_p);
      end
   end

endmodule

// File: rtl/cnn_window_addr_gen.sv
// Walks a square kernel window over a single-channel feature map and streams
// the row-major read address of every tap, with first/last-of-window flags.
module cnn_window_addr_gen
   import cnn_pkg::*;
#(
   parameter int width_p = 8,
   parameter int height_p = 8,
   parameter int kernel_p = 3,
   parameter int stride_p = 1,
   parameter int addr_width_p = $clog2(width_p * height_p)
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    start_i,
   input  logic                    ready_i,
   output logic                    v_o,
   output logic [addr_width_p-1:0] addr_o,
   output logic                    first_o,
   output logic                    last_o,
   output logic                    busy_o,
   output logic                    done_o
);

   localparam int out_w_lp = cnn_out_dim(width_p, kernel_p, stride_p);
   localparam int out_h_lp = cnn_out_dim(height_p, kernel_p, stride_p);
   localparam int kw_lp    = (kernel_p > 1) ? $clog2(kernel_p) : 1;
   localparam int ow_lp    = (out_w_lp > 1) ? $clog2(out_w_lp) : 1;
   localparam int oh_lp    = (out_h_lp > 1) ? $clog2(out_h_lp) : 1;

   localparam logic [kw_lp-1:0] kmax_lp = kw_lp'(kernel_p - 1);

   typedef logic [addr_width_p-1:0] addr_t;

   if (((width_p - kernel_p) % stride_p) != 0 || ((height_p - kernel_p) % stride_p) != 0
       || kernel_p > width_p || kernel_p > height_p) begin : g_bad_cfg
      $error("cnn_window_addr_gen: kernel/stride do not tile the feature map");
   end

   cnn_agen_state_e state_q, state_n;
   logic            done_q, done_n;
   logic            handshake;

   logic [kw_lp-1:0] kx_cnt, ky_cnt;
   logic [ow_lp-1:0] ox_cnt;
   logic [oh_lp-1:0] oy_cnt;
   logic             kx_pulse, ky_pulse, ox_pulse, oy_pulse;

   assign handshake = v_o & ready_i;

   // Nested loops: each counter advances when the one below it wraps.
   cnn_counter #(.max_p(kernel_p), .stride_p(1)) u_kx (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(handshake), .count_o(kx_cnt), .pulse_o(kx_pulse)
   );

   cnn_counter #(.max_p(kernel_p), .stride_p(1)) u_ky (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(kx_pulse), .count_o(ky_cnt), .pulse_o(ky_pulse)
   );

   cnn_counter #(.max_p(out_w_lp), .stride_p(1)) u_ox (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(ky_pulse), .count_o(ox_cnt), .pulse_o(ox_pulse)
   );

   cnn_counter #(.max_p(out_h_lp), .stride_p(1)) u_oy (
      .clk_i(clk_i), .reset_i(reset_i), .en_i(ox_pulse), .count_o(oy_cnt), .pulse_o(oy_pulse)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_n;
         done_q  <= done_n;
      end
   end

   // The outermost wrap pulse can only occur on the handshake of the final tap.
   always_comb begin
      state_n = state_q;
      done_n  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) state_n = RUN;
         end
         RUN: begin
            if (oy_pulse) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign v_o     = (state_q == RUN);
   assign busy_o  = (state_q == RUN);
   assign done_o  = done_q;
   assign first_o = v_o & (kx_cnt == '0) & (ky_cnt == '0);
   assign last_o  = v_o & (kx_cnt == kmax_lp) & (ky_cnt == kmax_lp);

   // Stride lives here rather than in the counters; every term stays below width*height.
   assign addr_o = (addr_t'(oy_cnt) * addr_t'(stride_p) + addr_t'(ky_cnt)) * addr_t'(width_p)
                 + addr_t'(ox_cnt) * addr_t'(stride_p) + addr_t'(kx_cnt);

endmodule

// File: doc/cnn_window_addr_gen.md
Name: cnn_window_addr_gen

Overview:
- Downstream consumer of cnn_counter. Four cnn_counter instances are chained as nested loops to walk a convolution window over a single-channel feature map.
- Per output position, emits the feature-map read address of every kernel tap, with first/last-of-window flags, over a valid/ready stream.
- Sits between the convolution controller (start/done) and the feature-map memory read port / MAC accumulator.

Parameters:
- width_p, 8, feature-map width in pixels
- height_p, 8, feature-map height in pixels
- kernel_p, 3, kernel side length (square kernel)
- stride_p, 1, window stride in both dimensions
- addr_width_p, $clog2(width_p*height_p), address output width

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  start one full frame sweep (accepted only when idle)
- ready_i  in  1  consumer ready for addr_o
- v_o  out  1  addr_o/flags valid
- addr_o  out  addr_width_p  row-major pixel address
- first_o  out  1  current tap is (ky=0,kx=0) of its window
- last_o  out  1  current tap is (ky=kernel_p-1,kx=kernel_p-1) of its window
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse, sweep finished

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Derived constants:
  - out_w = (width_p-kernel_p)/stride_p+1
  - out_h = (height_p-kernel_p)/stride_p+1
  - Elaboration error if (width_p-kernel_p)%stride_p!=0, (height_p-kernel_p)%stride_p!=0, or kernel_p>width_p/height_p.
- Loop order, fastest first: kx (0..kernel_p-1), ky, ox (0..out_w-1), oy (0..out_h-1).
- Tap address: addr_o = (oy*stride_p+ky)*width_p + ox*stride_p + kx.
  - Computed combinationally from the counter registers.
  - Intermediate products are sized so they do not truncate below addr_width_p.
- FSM states:
  - IDLE: v_o=0, busy_o=0, all counters 0.
  - RUN: v_o=1, busy_o=1.
- Transitions:
  - IDLE & start_i -> RUN next cycle; first beat is addr 0 with first_o=1.
  - RUN: handshake = v_o & ready_i.
  - RUN: the kx counter en = handshake; each higher counter en = pulse_o of the next-lower counter.
  - RUN & handshake on the final tap (kx,ky,ox,oy all at max) -> IDLE. All counters wrap to 0.
  - done_o=1 in the first IDLE cycle only.
- Backpressure: while v_o & !ready_i, addr_o/first_o/last_o are held stable and no counter advances.
- start_i while in RUN is ignored; there is no queueing. start_i in the done_o cycle is accepted, since the state is IDLE.
- Latency: start_i at edge N gives v_o at cycle N+1. At one handshake per cycle, throughput is 1 tap/cycle, and a sweep takes out_w*out_h*kernel_p^2 beats.
- Reset values: v_o=0, busy_o=0, done_o=0, addr_o=0, first_o=0, last_o=0 (flags gated by v_o). State is IDLE and counters are 0.
- Reset mid-sweep: the sweep is abandoned and the next cycle is IDLE with no done_o. Reset overrides a simultaneous start_i.
- kernel_p=1: first_o and last_o are both 1 on every beat.

Decomposition:
- Shared package cnn_pkg holds:
  - the state enum (cnn_agen_state_e: IDLE, RUN);
  - a function computing the output dimension from (size, kernel, stride).
- Sub-module: cnn_counter, instantiated four times with max_p = kernel_p, kernel_p, out_w, out_h and stride_p=1.
  - Window stride is applied in the address arithmetic, not in the counters.
  - The block's own FSM and flag logic is the new RTL.

Test Plan:
- Full sweep, width 4, height 4, kernel 2, stride 1, ready_i=1:
  - 36 beats.
  - Window 0: 0,1,4,5. Window 1: 1,2,5,6. Last window: 10,11,14,15.
  - first_o on beats 0,4,...,32; last_o on beats 3,7,...,35.
  - done_o one cycle after beat 35.
- Stride 2, same map and kernel:
  - 16 beats; windows {0,1,4,5}, {2,3,6,7}, {8,9,12,13}, {10,11,14,15}.
- Backpressure: ready_i toggled 1,0,0,1 at random:
  - addr_o sequence is identical to the first case.
  - addr_o is stable on every ready_i=0 cycle; beat count is still 36.
- start_i pulsed mid-sweep at beat 10:
  - Ignored; exactly 36 beats and a single done_o.
  - start_i in the done_o cycle starts a new sweep whose first addr is 0.
- Reset at beat 20:
  - Next cycle v_o=0, busy_o=0 and no done_o.
  - A subsequent start_i begins again at addr 0 with first_o=1.
